reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (legal range 1-4).
REQ-004 SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding.
REQ-005 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have wr_en  input  1  write request.
REQ-008 SHALL have wr_addr  input  ADDR_WIDTH  write address.
REQ-009 SHALL have wr_data  input  DATA_WIDTH  write data.
REQ-010 SHALL have rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have rd_data  output  NUM_RD*DATA_WIDTH  packed read data; same packing as rd_addr.
REQ-012 SHALL have rd_pending  output  NUM_RD  scoreboard bit of each read port's address.
REQ-013 SHALL have sb_set_en  input  1  mark a register as pending (write outstanding).
REQ-014 SHALL have sb_set_addr  input  ADDR_WIDTH  register to mark pending.
REQ-015 SHALL have clr_req  input  1  single-cycle request to zero the whole file.
REQ-016 SHALL have clr_busy  output  1  clear sequence in progress.

Function
REQ-017 Register 0 SHALL read as 0 on every port; writes to address 0 SHALL be discarded; address 0 SHALL never be pending.
REQ-018 Reads SHALL be combinational: rd_data port k = array[rd_addr k] (0 for address 0).
REQ-019 Writes SHALL be synchronous: wr_en=1, clr_busy=0, wr_addr!=0 -> array[wr_addr] <= wr_data at the rising edge.
REQ-020 With BYPASS=1, wr_en=1, clr_busy=0, rd_addr k == wr_addr != 0, port k SHALL return wr_data in the same cycle; with BYPASS=0 it SHALL return the old value.
REQ-021 Scoreboard: one pending bit per register; sb_set_en=1, sb_set_addr!=0 SHALL set the bit at the edge.
REQ-022 An accepted write SHALL clear the pending bit of wr_addr at the edge.
REQ-023 Simultaneous sb_set_en and accepted write to the same address: set SHALL win (bit ends 1).
REQ-024 rd_pending k SHALL be the current pending bit of rd_addr k, combinational; with BYPASS=1 a same-cycle accepted write to that address (without a same-address set) SHALL force rd_pending k to 0.
REQ-025 Clear FSM states SHALL be IDLE and CLEAR.
REQ-026 IDLE -> CLEAR on clr_req=1; at that edge all pending bits SHALL clear and a counter SHALL load 1.
REQ-027 In CLEAR each edge SHALL write 0 to array[counter] and increment the counter; after writing DEPTH-1 the FSM SHALL return to IDLE.
REQ-028 clr_busy SHALL be 1 exactly while in CLEAR: DEPTH-1 cycles, starting the cycle after clr_req is sampled.
REQ-029 During CLEAR, wr_en and sb_set_en SHALL be ignored, bypass SHALL be disabled, and clr_req SHALL be ignored (no restart).
REQ-030 Reads during CLEAR SHALL return current array contents (already-cleared entries read 0).
REQ-031 clr_req and wr_en in the same IDLE cycle: the write SHALL be performed, then clearing overwrites it.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: all array entries 0, all pending bits 0, FSM IDLE, counter 0, clr_busy 0.
REQ-033 Reset asserted mid-CLEAR SHALL abort the sequence; after release the block SHALL be in IDLE with clr_busy=0.
REQ-034 After release, the first rising edge with rst_n=1 SHALL accept writes.

Verification
REQ-035 Reset then read all addresses on all ports -> rd_data all 0, rd_pending all 0, clr_busy 0.
REQ-036 Write 0xDEADBEEF to r5 with rd_addr0=5 same cycle -> BYPASS=1: rd_data0=0xDEADBEEF that cycle; BYPASS=0: 0 that cycle, 0xDEADBEEF next cycle.
REQ-037 Write 0x1234 to r0 -> all ports read r0 = 0; sb_set_en to r0 -> rd_pending stays 0.
REQ-038 sb_set r7; next cycle rd_addr1=7 -> rd_pending1=1; write r7 -> rd_pending1=0 next cycle; set and write r7 same cycle -> pending 1.
REQ-039 Fill r1..r31 with nonzero values, pulse clr_req -> clr_busy high for 31 cycles, wr_en during CLEAR ignored, all reads 0 afterwards.
REQ-040 Pulse clr_req, assert rst_n=0 after 10 cycles -> clr_busy drops immediately, all registers 0, normal write succeeds after release.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: write, read, scoreboard and clear signals of the multi-port register file
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic                         wr_en;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [DATA_WIDTH-1:0]        wr_data;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_pending;
    logic                         sb_set_en;
    logic [ADDR_WIDTH-1:0]        sb_set_addr;
    logic                         clr_req;
    logic                         clr_busy;
    modport master (output wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr, clr_req,
                    input rd_data, rd_pending, clr_busy);
    modport slave (input wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr, clr_req,
                   output rd_data, rd_pending, clr_busy);
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with zero register, write bypass, pending scoreboard and sequential clear
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_ok, set_ok;
    assign wr_ok  = bus.wr_en && state_q == IDLE && bus.wr_addr != '0;
    assign set_ok = bus.sb_set_en && state_q == IDLE && bus.sb_set_addr != '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end
    // set is applied after the write-clear so a same-address set wins; a clear request wipes everything
    always_comb begin
        state_d = state_q == IDLE ? (bus.clr_req ? CLEAR : IDLE) : (cnt_q == LAST ? IDLE : CLEAR);
        cnt_d   = state_q == IDLE ? (bus.clr_req ? ADDR_WIDTH'(1) : cnt_q) : cnt_q + 1'b1;
        pend_d  = pend_q;
        if (wr_ok) pend_d[bus.wr_addr] = 1'b0;
        if (set_ok) pend_d[bus.sb_set_addr] = 1'b1;
        if (state_q == IDLE && bus.clr_req) pend_d = '0;
        pend_d[0] = 1'b0;
    end
    always_comb begin
        bus.clr_busy = state_q == CLEAR;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic                  hit;
        assign a   = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit = BYPASS != 0 && wr_ok && bus.wr_addr == a;
        assign bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = a == '0 ? '0 : hit ? bus.wr_data : mem_q[a];
        assign bus.rd_pending[k] = pend_q[a] && !(hit && !(set_ok && bus.sb_set_addr == a));
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed vector table plus clear and reset sequences for reg_file_mp
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;
    always #5 clk = ~clk;
    reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) bus ();
    reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) bus0 ();
    reg_file_mp #(.BYPASS(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    reg_file_mp #(.BYPASS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    assign bus0.wr_en       = bus.wr_en;
    assign bus0.wr_addr     = bus.wr_addr;
    assign bus0.wr_data     = bus.wr_data;
    assign bus0.rd_addr     = bus.rd_addr;
    assign bus0.sb_set_en   = bus.sb_set_en;
    assign bus0.sb_set_addr = bus.sb_set_addr;
    assign bus0.clr_req     = bus.clr_req;
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a0, a1;
        logic        se;
        logic [4:0]  sa;
        logic [31:0] e0, e1;
        logic        ep0, ep1;
        logic [31:0] enb0;
    } vec_t;
    vec_t vecs [13];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] a0,
                       input logic [4:0] a1, input logic se, input logic [4:0] sa, input logic cr);
        bus.wr_en = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_addr = {a1, a0};
        bus.sb_set_en = se;
        bus.sb_set_addr = sa;
        bus.clr_req = cr;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        //       we    wa     wd            a0     a1     se    sa     e0            e1            p0    p1    nb0
        vecs[0]  = '{1'b0, 5'd0, 32'h0,        5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5,  5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        5'd5,  5'd5,  1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 5'd0, 32'h1234,     5'd0,  5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        5'd3,  5'd7,  1'b1, 5'd7,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        5'd7,  5'd7,  1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 5'd7, 32'hA5,       5'd7,  5'd3,  1'b0, 5'd0,  32'hA5,       32'h0,        1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        5'd3,  5'd7,  1'b0, 5'd0,  32'h0,        32'hA5,       1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 5'd7, 32'h77,       5'd7,  5'd7,  1'b1, 5'd7,  32'h77,       32'h77,       1'b0, 1'b0, 32'hA5};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        5'd7,  5'd7,  1'b0, 5'd0,  32'h77,       32'h77,       1'b1, 1'b1, 32'h77};
        vecs[11] = '{1'b1, 5'd3, 32'h33,       5'd3,  5'd5,  1'b0, 5'd0,  32'h33,       32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        5'd3,  5'd31, 1'b0, 5'd0,  32'h33,       32'h0,        1'b0, 1'b0, 32'h33};
        drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            drv(1'b0, 5'd0, 32'h0, 5'(a), 5'(a), 1'b0, 5'd0, 1'b0);
            #1;
            chk("reset rd_data", bus.rd_data[31:0] | bus.rd_data[63:32], 32'h0);
            chk("reset rd_pending", 32'(bus.rd_pending), 32'h0);
            chk("reset clr_busy", 32'(bus.clr_busy), 32'h0);
        end
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drv(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a0, vecs[i].a1, vecs[i].se, vecs[i].sa, 1'b0);
            #1;
            chk($sformatf("vec%0d rd_data0", i), bus.rd_data[31:0], vecs[i].e0);
            chk($sformatf("vec%0d rd_data1", i), bus.rd_data[63:32], vecs[i].e1);
            chk($sformatf("vec%0d rd_pending0", i), 32'(bus.rd_pending[0]), 32'(vecs[i].ep0));
            chk($sformatf("vec%0d rd_pending1", i), 32'(bus.rd_pending[1]), 32'(vecs[i].ep1));
            chk($sformatf("vec%0d nobypass rd_data0", i), bus0.rd_data[31:0], vecs[i].enb0);
        end
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drv(1'b1, 5'(i), i * 32'h01010101, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        end
        @(negedge clk);
        drv(1'b1, 5'd4, 32'hFFFF, 5'd31, 5'd0, 1'b0, 5'd0, 1'b1);
        #1;
        chk("fill r31", bus.rd_data[31:0], 32'h1F1F1F1F);
        @(negedge clk);
        drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0);
        #1;
        chk("write with clr_req r4", bus.rd_data[63:32], 32'hFFFF);
        n = 0;
        while (bus.clr_busy && n < 100) begin
            if (n == 2) begin
                drv(1'b1, 5'd20, 32'hBAD, 5'd20, 5'd0, 1'b1, 5'd20, 1'b1);
                #1;
                chk("clear no bypass", bus.rd_data[31:0], 32'h14141414);
                chk("clear no pending", 32'(bus.rd_pending[0]), 32'h0);
            end else begin
                drv(1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0);
            end
            n++;
            @(negedge clk);
            #1;
        end
        chk("clr_busy cycles", 32'(n), 32'd31);
        for (int a = 0; a < 32; a++) begin
            drv(1'b0, 5'd0, 32'h0, 5'(a), 5'(a), 1'b0, 5'd0, 1'b0);
            #1;
            chk($sformatf("after clear r%0d", a), bus.rd_data[31:0] | bus.rd_data[63:32], 32'h0);
            chk($sformatf("after clear pend r%0d", a), 32'(bus.rd_pending), 32'h0);
        end
        @(negedge clk);
        drv(1'b1, 5'd25, 32'h2525, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        drv(1'b0, 5'd0, 32'h0, 5'd25, 5'd0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        drv(1'b0, 5'd0, 32'h0, 5'd25, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        chk("pre-reset busy", 32'(bus.clr_busy), 32'h1);
        chk("pre-reset r25", bus.rd_data[31:0], 32'h2525);
        #1 rst_n = 1'b0;
        #1;
        chk("reset busy drop", 32'(bus.clr_busy), 32'h0);
        chk("reset r25", bus.rd_data[31:0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drv(1'b1, 5'd25, 32'h55, 5'd25, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("release busy", 32'(bus.clr_busy), 32'h0);
        chk("release nobypass r25", bus0.rd_data[31:0], 32'h0);
        @(negedge clk);
        drv(1'b0, 5'd0, 32'h0, 5'd25, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("post-reset write", bus.rd_data[31:0], 32'h55);
        chk("post-reset write nobypass", bus0.rd_data[31:0], 32'h55);
        chk("post-reset busy", 32'(bus.clr_busy), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
